// File: rtl/mc_ctrl_hs.sv
// mc_ctrl_hs: multicycle MIPS control FSM with a memory ready handshake and a bounded wait timeout.
// Optional build macro MC_CTRL_ILLEGAL_TRAP_EN sends unlisted Op/Funct pairs through S_TRAP.
module mc_ctrl_hs #(
  parameter int ALUOP_W  = 4,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Zero,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               mem_rdy,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               EXTOp,
  output logic               IorD,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               mem_req,
  output logic [2:0]         state_o,
  output logic               instr_done,
  output logic               mem_err
);

  // Handshake: an access completes in a cycle where mem_req and mem_rdy are both high;
  // mem_rdy is don't-care while mem_req is low.
  typedef enum logic [2:0] {
    S_IF = 3'b000, S_ID = 3'b001, S_EXE = 3'b010,
    S_MEM = 3'b011, S_WB = 3'b100, S_TRAP = 3'b101
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c,
                         OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SLLV = 6'h04, F_SRLV = 6'h06,
                         F_JR = 6'h08, F_JALR = 6'h09, F_ADD = 6'h20, F_ADDU = 6'h21,
                         F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25,
                         F_NOR = 6'h27, F_SLT = 6'h2a, F_SLTU = 6'h2b;
  localparam logic [3:0] ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3, ALU_OR = 4'd4,
                         ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8,
                         ALU_NOR = 4'd9, ALU_LUI = 4'd10, ALU_SLLV = 4'd11, ALU_SRLV = 4'd12;
  localparam logic [CNT_W-1:0] WAIT_MAX_C = CNT_W'(WAIT_MAX);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             req_st, timeout;
  logic             is_j, is_jal, is_beq, is_bne, is_lw, is_sw, is_shift;
  logic             is_itype, is_ext0, is_jr, is_jalr, legal;
  logic [3:0]       alu_sel, alu4;

  always_comb begin
    is_j = 1'b0; is_jal = 1'b0; is_beq = 1'b0; is_bne = 1'b0; is_lw = 1'b0;
    is_sw = 1'b0; is_shift = 1'b0; is_itype = 1'b0; is_ext0 = 1'b0;
    is_jr = 1'b0; is_jalr = 1'b0; legal = 1'b1; alu_sel = 4'b0000;
    case (Op)
      OP_R: begin
        case (Funct)
          F_ADD, F_ADDU: alu_sel = ALU_ADD;
          F_SUB, F_SUBU: alu_sel = ALU_SUB;
          F_AND:         alu_sel = ALU_AND;
          F_OR:          alu_sel = ALU_OR;
          F_NOR:         alu_sel = ALU_NOR;
          F_SLT:         alu_sel = ALU_SLT;
          F_SLTU:        alu_sel = ALU_SLTU;
          F_SLLV:        alu_sel = ALU_SLLV;
          F_SRLV:        alu_sel = ALU_SRLV;
          F_SLL:         begin alu_sel = ALU_SLL; is_shift = 1'b1; end
          F_SRL:         begin alu_sel = ALU_SRL; is_shift = 1'b1; end
          F_JR:          begin alu_sel = ALU_ADD; is_jr = 1'b1; end
          F_JALR:        begin alu_sel = ALU_ADD; is_jalr = 1'b1; end
          default:       legal = 1'b0;
        endcase
      end
      OP_J:    begin alu_sel = ALU_ADD; is_j = 1'b1; end
      OP_JAL:  begin alu_sel = ALU_ADD; is_jal = 1'b1; end
      OP_BEQ:  begin alu_sel = ALU_SUB; is_beq = 1'b1; end
      OP_BNE:  begin alu_sel = ALU_SUB; is_bne = 1'b1; end
      OP_ADDI: begin alu_sel = ALU_ADD; is_itype = 1'b1; end
      OP_SLTI: begin alu_sel = ALU_SLT; is_itype = 1'b1; end
      OP_ANDI: begin alu_sel = ALU_AND; is_itype = 1'b1; is_ext0 = 1'b1; end
      OP_ORI:  begin alu_sel = ALU_OR;  is_itype = 1'b1; is_ext0 = 1'b1; end
      OP_LUI:  begin alu_sel = ALU_LUI; is_itype = 1'b1; end
      OP_LW:   begin alu_sel = ALU_ADD; is_lw = 1'b1; end
      OP_SW:   begin alu_sel = ALU_ADD; is_sw = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  assign req_st  = (state == S_IF) || (state == S_MEM);
  assign timeout = req_st && !mem_rdy && (wait_cnt == WAIT_MAX_C);
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IF;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      // An IF timeout keeps the state, so it must clear the counter explicitly.
      if (mem_rdy || timeout || (state_nxt != state)) wait_cnt <= '0;
      else if (req_st)                                 wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = S_IF;
    case (state)
      S_IF:  state_nxt = mem_rdy ? S_ID : S_IF;
      S_ID: begin
        if (is_j || is_jal) state_nxt = S_IF;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        else if (!legal)    state_nxt = S_TRAP;
`endif
        else                state_nxt = S_EXE;
      end
      S_EXE: begin
        if (is_beq || is_bne || is_jr) state_nxt = S_IF;
        else if (is_lw || is_sw)       state_nxt = S_MEM;
        else                           state_nxt = S_WB;
      end
      S_MEM: begin
        if (mem_rdy)      state_nxt = is_lw ? S_WB : S_IF;
        else if (timeout) state_nxt = S_IF;
        else              state_nxt = S_MEM;
      end
      default: state_nxt = S_IF;
    endcase
  end

  always_comb begin
    RegWrite = 1'b0; MemWrite = 1'b0; PCWrite = 1'b0; IRWrite = 1'b0;
    EXTOp = 1'b1; IorD = 1'b0; ALUSrcA = 2'b01; ALUSrcB = 2'b00;
    PCSource = 2'b00; GPRSel = 2'b00; WDSel = 2'b00; alu4 = ALU_ADD;
    mem_req = 1'b0; instr_done = 1'b0; mem_err = 1'b0;
    case (state)
      S_IF: begin
        mem_req = 1'b1; ALUSrcA = 2'b00; ALUSrcB = 2'b01;
        PCWrite = mem_rdy; IRWrite = mem_rdy;
      end
      S_ID: begin
        if (is_j || is_jal) begin
          PCSource = 2'b10; PCWrite = 1'b1; instr_done = 1'b1;
          if (is_jal) begin RegWrite = 1'b1; WDSel = 2'b10; GPRSel = 2'b10; end
        end else begin
          ALUSrcA = 2'b00; ALUSrcB = 2'b11;
        end
      end
      S_EXE: begin
        alu4  = alu_sel;
        EXTOp = ~is_ext0;
        if (is_beq || is_bne) begin
          PCSource = 2'b01; PCWrite = is_beq ? Zero : ~Zero; instr_done = 1'b1;
        end
        if (is_lw || is_sw || is_itype) ALUSrcB = 2'b10;
        if (is_shift) ALUSrcA = 2'b10;
        if (is_jr || is_jalr) begin
          PCSource = 2'b11; PCWrite = 1'b1; instr_done = is_jr;
        end
      end
      S_MEM: begin
        IorD = 1'b1; mem_req = 1'b1;
        if (is_sw) begin MemWrite = mem_rdy; instr_done = mem_rdy; end
      end
      S_WB: begin
        RegWrite = 1'b1; instr_done = 1'b1;
        if (is_lw) WDSel = 2'b01;
        if (is_lw || is_itype) GPRSel = 2'b01;
        if (is_jalr) WDSel = 2'b10;
        if (!legal) alu4 = 4'b0000;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        PCSource = 2'b11; ALUSrcA = 2'b11; PCWrite = 1'b1;
      end
`endif
      default: ;
    endcase
    if (timeout) begin
      RegWrite = 1'b0; MemWrite = 1'b0; PCWrite = 1'b0; IRWrite = 1'b0;
      instr_done = 1'b0; mem_err = 1'b1;
    end
    // Reset abandons the instruction in flight: nothing is written in the reset cycle.
    if (rst) begin
      RegWrite = 1'b0; MemWrite = 1'b0; PCWrite = 1'b0; IRWrite = 1'b0;
      mem_req = 1'b0; instr_done = 1'b0; mem_err = 1'b0;
    end
  end

  always_comb begin
    ALUOp      = '0;
    ALUOp[3:0] = alu4;
  end

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Testbench for mc_ctrl_hs: per-instruction cycle traces from an instruction-level model.
module tb_mc_ctrl_hs;
  localparam int WAIT_MAX = 15;
  localparam int OW = 26;
  localparam int K_J = 0, K_JAL = 1, K_BR = 2, K_JR = 3, K_JALR = 4, K_LW = 5,
                 K_SW = 6, K_RALU = 7, K_SHIFT = 8, K_IALU = 9, K_ILL = 10;

  logic clk = 1'b0, rst, Zero, mem_rdy;
  logic [5:0] Op, Funct;
  logic RegWrite, MemWrite, PCWrite, IRWrite, EXTOp, IorD, mem_req, instr_done, mem_err;
  logic [1:0] ALUSrcA, ALUSrcB, PCSource, GPRSel, WDSel;
  logic [3:0] ALUOp;
  logic [2:0] state_o;

  typedef struct packed {
    logic [2:0] st;
    logic rw, mw, pcw, irw, ext, iord, req, done, err;
    logic [1:0] sa, sb, pcs, gpr, wd;
    logic [3:0] alu;
  } cyc_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         kind;
    logic [3:0] alu;
    logic       ext0;
    logic       bne;
  } ins_t;

  ins_t tbl[$];
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] obs_q[$];
  logic rdy_q[$];
  int n_pass = 0, n_total = 0;
  cyc_t obs_now;

  always #5 clk = ~clk;

  mc_ctrl_hs dut (
    .clk(clk), .rst(rst), .Zero(Zero), .Op(Op), .Funct(Funct), .mem_rdy(mem_rdy),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .EXTOp(EXTOp), .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .GPRSel(GPRSel), .WDSel(WDSel), .ALUOp(ALUOp),
    .mem_req(mem_req), .state_o(state_o), .instr_done(instr_done), .mem_err(mem_err)
  );

  assign obs_now = {state_o, RegWrite, MemWrite, PCWrite, IRWrite, EXTOp, IorD, mem_req,
                    instr_done, mem_err, ALUSrcA, ALUSrcB, PCSource, GPRSel, WDSel, ALUOp};

  task automatic add_ins(input logic [5:0] op, input logic [5:0] fn, input int kind,
                         input logic [3:0] alu, input logic ext0, input logic bne);
    ins_t t;
    t.op = op; t.fn = fn; t.kind = kind; t.alu = alu; t.ext0 = ext0; t.bne = bne;
    tbl.push_back(t);
  endtask

  task automatic init_tbl();
    add_ins(6'h00, 6'h20, K_RALU, 4'd1, 0, 0);  add_ins(6'h00, 6'h21, K_RALU, 4'd1, 0, 0);
    add_ins(6'h00, 6'h22, K_RALU, 4'd2, 0, 0);  add_ins(6'h00, 6'h23, K_RALU, 4'd2, 0, 0);
    add_ins(6'h00, 6'h24, K_RALU, 4'd3, 0, 0);  add_ins(6'h00, 6'h25, K_RALU, 4'd4, 0, 0);
    add_ins(6'h00, 6'h27, K_RALU, 4'd9, 0, 0);  add_ins(6'h00, 6'h2a, K_RALU, 4'd5, 0, 0);
    add_ins(6'h00, 6'h2b, K_RALU, 4'd6, 0, 0);  add_ins(6'h00, 6'h04, K_RALU, 4'd11, 0, 0);
    add_ins(6'h00, 6'h06, K_RALU, 4'd12, 0, 0); add_ins(6'h00, 6'h00, K_SHIFT, 4'd7, 0, 0);
    add_ins(6'h00, 6'h02, K_SHIFT, 4'd8, 0, 0); add_ins(6'h00, 6'h08, K_JR, 4'd1, 0, 0);
    add_ins(6'h00, 6'h09, K_JALR, 4'd1, 0, 0);  add_ins(6'h08, 6'h00, K_IALU, 4'd1, 0, 0);
    add_ins(6'h0a, 6'h00, K_IALU, 4'd5, 0, 0);  add_ins(6'h0c, 6'h00, K_IALU, 4'd3, 1, 0);
    add_ins(6'h0d, 6'h00, K_IALU, 4'd4, 1, 0);  add_ins(6'h0f, 6'h00, K_IALU, 4'd10, 0, 0);
    add_ins(6'h23, 6'h00, K_LW, 4'd1, 0, 0);    add_ins(6'h2b, 6'h00, K_SW, 4'd1, 0, 0);
    add_ins(6'h04, 6'h00, K_BR, 4'd2, 0, 0);    add_ins(6'h05, 6'h00, K_BR, 4'd2, 0, 1);
    add_ins(6'h02, 6'h00, K_J, 4'd1, 0, 0);     add_ins(6'h03, 6'h00, K_JAL, 4'd1, 0, 0);
  endtask

  // Funct only matters for Op=0; anything not in the table is an illegal instruction.
  function automatic ins_t find(input logic [5:0] op, input logic [5:0] fn);
    ins_t t;
    t.op = op; t.fn = fn; t.kind = K_ILL; t.alu = 4'd0; t.ext0 = 1'b0; t.bne = 1'b0;
    foreach (tbl[i]) if (tbl[i].op == op && (op != 6'h00 || tbl[i].fn == fn)) t = tbl[i];
    return t;
  endfunction

  function automatic cyc_t dflt(input logic [2:0] st);
    cyc_t c;
    c = '0; c.st = st; c.ext = 1'b1; c.sa = 2'b01; c.alu = 4'd1;
    return c;
  endfunction

  task automatic push(input cyc_t c, input logic r);
    exp_q.push_back(c);
    rdy_q.push_back(r);
  endtask

  // Expected trace of one instruction; mem_rdy is random whenever no access is pending.
  task automatic build(input ins_t t, input logic z, input int if_wait, input int mem_wait);
    cyc_t c;
    int cnt;
    cnt = 0;
    for (int i = 0; i < if_wait; i++) begin
      c = dflt(3'd0); c.req = 1; c.sa = 2'd0; c.sb = 2'd1;
      if (cnt == WAIT_MAX) begin c.err = 1; cnt = 0; end else cnt++;
      push(c, 1'b0);
    end
    c = dflt(3'd0); c.req = 1; c.sa = 2'd0; c.sb = 2'd1; c.pcw = 1; c.irw = 1;
    push(c, 1'b1);
    c = dflt(3'd1);
    if (t.kind == K_J || t.kind == K_JAL) begin
      c.pcs = 2'd2; c.pcw = 1; c.done = 1;
      if (t.kind == K_JAL) begin c.rw = 1; c.wd = 2'd2; c.gpr = 2'd2; end
      push(c, 1'($urandom_range(0, 1)));
      return;
    end
    c.sa = 2'd0; c.sb = 2'd3;
    push(c, 1'($urandom_range(0, 1)));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    if (t.kind == K_ILL) begin
      c = dflt(3'd5); c.pcs = 2'd3; c.sa = 2'd3; c.pcw = 1;
      push(c, 1'($urandom_range(0, 1)));
      return;
    end
`endif
    c = dflt(3'd2); c.alu = t.alu; c.ext = !t.ext0;
    case (t.kind)
      K_BR: begin
        c.pcs = 2'd1; c.pcw = t.bne ? !z : z; c.done = 1;
        push(c, 1'($urandom_range(0, 1)));
        return;
      end
      K_JR: begin
        c.pcs = 2'd3; c.pcw = 1; c.done = 1;
        push(c, 1'($urandom_range(0, 1)));
        return;
      end
      K_JALR: begin c.pcs = 2'd3; c.pcw = 1; end
      K_LW, K_SW, K_IALU: c.sb = 2'd2;
      K_SHIFT: c.sa = 2'd2;
      default: ;
    endcase
    push(c, 1'($urandom_range(0, 1)));
    if (t.kind == K_LW || t.kind == K_SW) begin
      cnt = 0;
      for (int i = 0; i < mem_wait; i++) begin
        c = dflt(3'd3); c.iord = 1; c.req = 1;
        if (cnt == WAIT_MAX) begin c.err = 1; push(c, 1'b0); return; end
        cnt++;
        push(c, 1'b0);
      end
      c = dflt(3'd3); c.iord = 1; c.req = 1;
      if (t.kind == K_SW) begin c.mw = 1; c.done = 1; push(c, 1'b1); return; end
      push(c, 1'b1);
    end
    c = dflt(3'd4); c.rw = 1; c.done = 1;
    if (t.kind == K_LW) begin c.wd = 2'd1; c.gpr = 2'd1; end
    if (t.kind == K_IALU) c.gpr = 2'd1;
    if (t.kind == K_JALR) c.wd = 2'd2;
    if (t.kind == K_ILL) c.alu = 4'd0;
    push(c, 1'($urandom_range(0, 1)));
  endtask

  // Sets up one instruction and runs its whole expected trace; ends at posedge+1 in S_IF.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int if_wait, input int mem_wait);
    exp_q.delete(); rdy_q.delete(); obs_q.delete();
    Op = op; Funct = fn; Zero = z;
    build(find(op, fn), z, if_wait, mem_wait);
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_rdy = rdy_q[i];
      @(negedge clk);
      obs_q.push_back(obs_now);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1; mem_rdy = 1; Op = 6'h00; Funct = 6'h20; Zero = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_total++;
      if (state_o !== 3'b000) $display("FAIL reset_state: got %b exp 000", state_o);
      else n_pass++;
      n_total++;
      if ({RegWrite, MemWrite} !== 2'b00)
        $display("FAIL reset_writes: got RegWrite=%b MemWrite=%b exp 0 0", RegWrite, MemWrite);
      else n_pass++;
      @(posedge clk); #1;
    end
    rst = 0;
  endtask

  task automatic test_add_after_reset();
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL add cyc %0d: got %h exp %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_lw_waits();
    run_instr(6'h23, 6'h00, 1'b0, 3, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL lw_wait cyc %0d: got %h exp %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_sw_timeout();
    run_instr(6'h2b, 6'h00, 1'b0, 0, WAIT_MAX + 5);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL sw_timeout cyc %0d: got %h exp %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_if_timeout();
    run_instr(6'h0d, 6'h00, 1'b0, WAIT_MAX + 3, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL if_timeout cyc %0d: got %h exp %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 4; k++) begin
      run_instr((k < 2) ? 6'h05 : 6'h04, 6'h00, 1'(k % 2), k, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_total++;
        if (obs_q[i] !== exp_q[i])
          $display("FAIL branch%0d cyc %0d: got %h exp %h", k, i, obs_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_jalr();
    run_instr(6'h00, 6'h09, 1'b1, 1, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL jalr cyc %0d: got %h exp %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_illegal();
    run_instr(6'h3f, 6'($urandom_range(0, 63)), 1'b0, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL illegal cyc %0d: got %h exp %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  // Reset asserted in add's WB cycle and in sw's MEM cycle with mem_rdy high.
  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      Op = (k == 0) ? 6'h00 : 6'h2b; Funct = 6'h20; Zero = 0; mem_rdy = 1;
      @(posedge clk); #1;
      mem_rdy = 0;
      repeat (2) begin @(posedge clk); #1; end
      if (k == 1) mem_rdy = 1;
      rst = 1;
      @(negedge clk);
      n_total++;
      if (state_o !== ((k == 0) ? 3'd4 : 3'd3) || RegWrite !== 1'b0 || MemWrite !== 1'b0)
        $display("FAIL reset_mid%0d: got state=%b RegWrite=%b MemWrite=%b exp state=%0d 0 0",
                 k, state_o, RegWrite, MemWrite, (k == 0) ? 4 : 3);
      else n_pass++;
      @(posedge clk); #1;
      @(negedge clk);
      n_total++;
      if (state_o !== 3'd0) $display("FAIL reset_mid%0d_state: got %b exp 000", k, state_o);
      else n_pass++;
      @(posedge clk); #1;
      rst = 0;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] op, fn;
    int idx;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom_range(0, 63)); fn = 6'($urandom_range(0, 63));
      end else begin
        idx = $urandom_range(0, tbl.size() - 1);
        op = tbl[idx].op;
        fn = (op == 6'h00) ? tbl[idx].fn : 6'($urandom_range(0, 63));
      end
      run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
      for (int i = 0; i < exp_q.size(); i++) begin
        n_total++;
        if (obs_q[i] !== exp_q[i])
          $display("FAIL b2b op=%h fn=%h cyc %0d: got %h exp %h", op, fn, i, obs_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    init_tbl();
    test_reset();
    test_add_after_reset();
    test_lw_waits();
    test_sw_timeout();
    test_if_timeout();
    test_branch();
    test_jalr();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_hs.md
Name: mc_ctrl_hs

Overview:
- Next-generation multicycle MIPS control unit for the multicycle CPU datapath. It replaces the fixed-latency IF/ID/EXE/MEM/WB controller.
- Adds a memory ready handshake with wait states, a bounded wait timeout, a parametrised ALUOp width, and status outputs (state, retire pulse, error).
- Drives the same datapath mux/enable signals.

Parameters:
- ALUOP_W, 4, ALUOp width; must be >= 4; bits above [3] are driven 0.
- WAIT_MAX, 15, maximum stall cycles allowed while waiting for mem_rdy.
- CNT_W, 4, wait-counter width; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Zero  in  1  ALU zero flag.
- Op  in  6  opcode.
- Funct  in  6  funct field.
- mem_rdy  in  1  memory completes the current access this cycle.
- RegWrite, MemWrite, PCWrite, IRWrite, EXTOp, IorD  out  1 each  datapath controls.
- ALUSrcA, ALUSrcB, PCSource, GPRSel, WDSel  out  2 each  mux selects.
- ALUOp  out  ALUOP_W  ALU operation.
- mem_req  out  1  memory access request.
- state_o  out  3  current state.
- instr_done  out  1  one-cycle pulse, instruction retired.
- mem_err  out  1  one-cycle pulse, wait timeout.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
  - On rst: state<=S_IF (000), wait counter<=0.
  - Reset mid-instruction abandons it: no RegWrite or MemWrite occurs in the reset cycle.
- State encoding: S_IF=000, S_ID=001, S_EXE=010, S_MEM=011, S_WB=100, S_TRAP=101. All other codes go to S_IF.
- Control outputs are combinational from state, Op, Funct, Zero and mem_rdy.
- Default output values, applying in every state unless overridden below:
  - all enables 0, EXTOp=1, ALUSrcA=01, ALUSrcB=00, ALUOp=ADD.
  - GPRSel=00, WDSel=00, PCSource=00, IorD=0, mem_req=0.
- S_IF:
  - mem_req=1, ALUSrcA=00, ALUSrcB=01.
  - PCWrite and IRWrite equal mem_rdy.
  - On mem_rdy go to S_ID; otherwise stay.
- S_ID:
  - j: PCSource=10, PCWrite=1, instr_done=1, next state S_IF.
  - jal: same as j, plus RegWrite=1, WDSel=10, GPRSel=10.
  - All other instructions: ALUSrcA=00, ALUSrcB=11, next state S_EXE.
- S_EXE:
  - ALUOp encodings:
    - ADD 0001: add, addu, addi, lw, sw.
    - SUB 0010: sub, subu, beq, bne.
    - AND 0011: and, andi.
    - OR 0100: or, ori.
    - SLT 0101: slt, slti.
    - SLTU 0110: sltu.
    - SLL 0111: sll.
    - SRL 1000: srl.
    - NOR 1001: nor.
    - LUI 1010: lui.
    - SLLV 1011: sllv.
    - SRLV 1100: srlv.
  - beq: PCSource=01, PCWrite=Zero, instr_done=1, next state S_IF.
  - bne: PCSource=01, PCWrite=~Zero, instr_done=1, next state S_IF.
  - lw/sw: ALUSrcB=10, next state S_MEM.
  - sll/srl: ALUSrcA=10, next state S_WB.
  - addi/ori/andi/lui/slti: ALUSrcB=10, next state S_WB.
  - ori/andi additionally: EXTOp=0.
  - jr/jalr: PCSource=11, PCWrite=1.
    - jr: instr_done=1, next state S_IF.
    - jalr: next state S_WB.
  - Other R-type instructions: next state S_WB.
- S_MEM:
  - IorD=1, mem_req=1.
  - sw: MemWrite=mem_rdy. On mem_rdy, instr_done=1 and next state S_IF.
  - lw: on mem_rdy go to S_WB.
  - Without mem_rdy, stay in S_MEM.
- S_WB:
  - RegWrite=1, instr_done=1, next state S_IF.
  - lw: WDSel=01.
  - I-type ALU ops and lw: GPRSel=01.
  - jalr: WDSel=10, GPRSel=00.
- Wait counter:
  - Increments each cycle that mem_req=1 and mem_rdy=0.
  - Clears on mem_rdy, on any state change, and on rst.
- Timeout:
  - Condition: counter==WAIT_MAX and mem_rdy=0.
  - Response: mem_err=1 for that cycle, all write enables 0, next state S_IF, counter<=0.
  - mem_rdy in that same cycle wins, so no error.
- Boundaries:
  - mem_rdy=1 on the first request cycle means zero wait states: IF takes 1 cycle.
  - WAIT_MAX=0 means any non-ready request cycle is a timeout.
  - mem_rdy is ignored when mem_req=0.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An Op/Funct pair not listed above, decoded in S_ID, goes to S_TRAP.
  - S_TRAP drives PCSource=11, ALUSrcA=11 (exception vector), PCWrite=1, instr_done=0, then S_IF.
  - state_o=101 is visible for one cycle.
- Undefined: unlisted instructions follow the "other R-type" path with ALUOp=0000 and RegWrite=1 in S_WB. S_TRAP is unreachable.

Test Plan:
- rst=1 for 2 cycles with mem_rdy=1 -> state_o=000, no RegWrite/MemWrite; after release, IF+ID+EXE+WB for add takes 4 cycles, instr_done pulses in the WB cycle.
- lw with mem_rdy low for 3 cycles in IF and 2 cycles in MEM -> IRWrite only in the 4th IF cycle; S_WB reached on the 3rd MEM cycle; WDSel=01, GPRSel=01.
- sw with mem_rdy held low and WAIT_MAX=15 -> mem_err pulses exactly on the 16th MEM cycle, MemWrite never asserts, next state_o=000.
- bne with Zero=0 -> PCWrite=1, PCSource=01; bne with Zero=1 -> PCWrite=0; both return to S_IF.
- jalr -> EXE cycle has PCWrite=1, PCSource=11; WB cycle has RegWrite=1, WDSel=10.
- Op=6'b111111 with MC_CTRL_ILLEGAL_TRAP_EN defined -> state_o=101 for one cycle, PCWrite=1, PCSource=11; with the macro undefined -> S_WB with ALUOp=0000.
